register_file: RTL and testbench

- RV32I general-purpose register file for the reduced core: 32 entries x 32 bits, two combinational read ports (rs1, rs2) and one synchronous write port (rd).
- x0 is hardwired to zero.
- The core drives read addresses from its instruction register during execute and writes results (ALU, load, link address) one clock later.

---
 rtl/register_file.sv | 61 ++++++
 tb/tb_register_file.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/register_file.sv
// register_file: RV32I general-purpose register file.
//   2**AddrWidth entries of DataWidth bits, two combinational read ports and
//   one synchronous write port. Entry 0 always reads as zero.
//   Optional build macro REGISTER_FILE_BYPASS_EN: a read port whose index
//   matches an active write returns the incoming write data in the same cycle.
//   Without the macro, reads return the stored value until the clock edge.
module register_file #(
    parameter int DataWidth = 32,
    parameter int AddrWidth = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [AddrWidth-1:0] rs1,
    output logic [DataWidth-1:0] rs1_data_out,
    input  logic [AddrWidth-1:0] rs2,
    output logic [DataWidth-1:0] rs2_data_out,
    input  logic [AddrWidth-1:0] rd,
    input  logic                 rd_write_enable,
    input  logic [DataWidth-1:0] rd_data_in
);

    localparam int NumRegs = 2 ** AddrWidth;

    logic [DataWidth-1:0] regs_q [NumRegs];
    logic                 wr_fire;

    // A write takes effect only out of reset and never targets x0.
    assign wr_fire = rst_n && rd_write_enable && (rd != '0);

    // Storage update: synchronous clear has priority over the write port.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NumRegs; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_fire) begin
            regs_q[rd] <= rd_data_in;
        end
    end

    // Read port 1: x0 forced to zero, optional same-cycle forwarding.
    always_comb begin
        rs1_data_out = (rs1 == '0) ? '0 : regs_q[rs1];
`ifdef REGISTER_FILE_BYPASS_EN
        if (wr_fire && (rs1 == rd)) begin
            rs1_data_out = rd_data_in;
        end
`endif
    end

    // Read port 2: same rules as port 1, evaluated independently.
    always_comb begin
        rs2_data_out = (rs2 == '0) ? '0 : regs_q[rs2];
`ifdef REGISTER_FILE_BYPASS_EN
        if (wr_fire && (rs2 == rd)) begin
            rs2_data_out = rd_data_in;
        end
`endif
    end

endmodule

// File: tb/tb_register_file.sv
// tb_register_file: self-checking bench for register_file.
//   Table-driven vectors, hand-written corner sequences and a randomized
//   phase compared against an array-based reference model.
module tb_register_file;

    logic        clk;
    logic        rst_n;
    logic [4:0]  rs1;
    logic [31:0] rs1_data_out;
    logic [4:0]  rs2;
    logic [31:0] rs2_data_out;
    logic [4:0]  rd;
    logic        rd_write_enable;
    logic [31:0] rd_data_in;

    register_file #(.DataWidth(32), .AddrWidth(5)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .rs1             (rs1),
        .rs1_data_out    (rs1_data_out),
        .rs2             (rs2),
        .rs2_data_out    (rs2_data_out),
        .rd              (rd),
        .rd_write_enable (rd_write_enable),
        .rd_data_in      (rd_data_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    logic [31:0] model [32];

    typedef struct {
        logic        rst_n;
        logic        we;
        logic [4:0]  rd;
        logic [31:0] data;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] exp1;
        logic [31:0] exp2;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            passed++;
        end
    endtask

    function automatic logic [31:0] exp_read(input logic [4:0] idx);
        if (idx == 5'd0) return 32'h0;
`ifdef REGISTER_FILE_BYPASS_EN
        if (rst_n && rd_write_enable && rd != 5'd0 && idx == rd) return rd_data_in;
`endif
        return model[idx];
    endfunction

    // Advance one clock edge, updating the model from the inputs present at the edge.
    task automatic tick();
        @(posedge clk);
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) model[i] = 32'h0;
        end else if (rd_write_enable && rd != 5'd0) begin
            model[rd] = rd_data_in;
        end
        #1;
    endtask

    task automatic write_reg(input logic [4:0] idx, input logic [31:0] val);
        rd = idx;
        rd_data_in = val;
        rd_write_enable = 1'b1;
        tick();
        rd_write_enable = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        rs1 = '0;
        rs2 = '0;
        rd = '0;
        rd_write_enable = 1'b0;
        rd_data_in = '0;
        for (int i = 0; i < 32; i++) model[i] = 32'h0;

        vecs[0] = '{1'b1, 1'b1, 5'd5,  32'hDEADBEEF, 5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF};
        vecs[1] = '{1'b1, 1'b0, 5'd5,  32'h00000000, 5'd5,  5'd6,  32'hDEADBEEF, 32'h00000000};
        vecs[2] = '{1'b1, 1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd5,  32'h00000000, 32'hDEADBEEF};
        vecs[3] = '{1'b1, 1'b1, 5'd7,  32'h11111111, 5'd7,  5'd0,  32'h11111111, 32'h00000000};
        vecs[4] = '{1'b1, 1'b0, 5'd7,  32'h99999999, 5'd7,  5'd5,  32'h11111111, 32'hDEADBEEF};
        vecs[5] = '{1'b0, 1'b1, 5'd3,  32'h12345678, 5'd3,  5'd5,  32'h00000000, 32'h00000000};
        vecs[6] = '{1'b1, 1'b1, 5'd31, 32'hA5A5A5A5, 5'd31, 5'd30, 32'hA5A5A5A5, 32'h00000000};
        vecs[7] = '{1'b1, 1'b1, 5'd31, 32'h5A5A5A5A, 5'd31, 5'd31, 32'h5A5A5A5A, 32'h5A5A5A5A};

        // Reset, then every index reads zero on both ports.
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 32; i++) begin
            rs1 = 5'(i);
            rs2 = 5'(31 - i);
            #1;
            check($sformatf("reset_rs1[%0d]", i), rs1_data_out, 32'h0);
            check($sformatf("reset_rs2[%0d]", 31 - i), rs2_data_out, 32'h0);
        end

        // Table vectors: apply one edge, release strobes, read back.
        for (int v = 0; v < 8; v++) begin
            rst_n = vecs[v].rst_n;
            rd_write_enable = vecs[v].we;
            rd = vecs[v].rd;
            rd_data_in = vecs[v].data;
            tick();
            rst_n = 1'b1;
            rd_write_enable = 1'b0;
            rs1 = vecs[v].rs1;
            rs2 = vecs[v].rs2;
            #1;
            check($sformatf("vec%0d_rs1", v), rs1_data_out, vecs[v].exp1);
            check($sformatf("vec%0d_rs2", v), rs2_data_out, vecs[v].exp2);
        end

        // Same-cycle read/write of x7; rs2 on an unrelated register never forwards.
        do_reset();
        write_reg(5'd7, 32'h11111111);
        write_reg(5'd8, 32'h88888888);
        rs1 = 5'd7;
        rs2 = 5'd8;
        rd = 5'd7;
        rd_data_in = 32'h22222222;
        rd_write_enable = 1'b1;
        #1;
`ifdef REGISTER_FILE_BYPASS_EN
        check("rdw_before_edge", rs1_data_out, 32'h22222222);
`else
        check("rdw_before_edge", rs1_data_out, 32'h11111111);
`endif
        check("rdw_other_port", rs2_data_out, 32'h88888888);
        tick();
        rd_write_enable = 1'b0;
        #1;
        check("rdw_after_edge", rs1_data_out, 32'h22222222);

        // Write to x0 while addressing it: never visible, even in the write cycle.
        rs1 = 5'd0;
        rd = 5'd0;
        rd_data_in = 32'hFFFFFFFF;
        rd_write_enable = 1'b1;
        #1;
        check("x0_during_write", rs1_data_out, 32'h0);
        tick();
        rd_write_enable = 1'b0;
        #1;
        check("x0_after_write", rs1_data_out, 32'h0);

        // Reset together with a write: reset wins, all entries clear.
        rst_n = 1'b0;
        rd_write_enable = 1'b1;
        rd = 5'd3;
        rd_data_in = 32'h12345678;
        tick();
        rst_n = 1'b1;
        rd_write_enable = 1'b0;
        rs1 = 5'd3;
        rs2 = 5'd7;
        #1;
        check("reset_prio_x3", rs1_data_out, 32'h0);
        check("reset_prio_x7", rs2_data_out, 32'h0);

        // Fill x1..x31, idle cycles with junk on rd/data, then read pairs.
        for (int i = 1; i < 32; i++) write_reg(5'(i), 32'(i) * 32'h01010101);
        for (int k = 0; k < 6; k++) begin
            rd_write_enable = 1'b0;
            rd = 5'($urandom_range(0, 31));
            rd_data_in = $urandom;
            tick();
        end
        for (int i = 1; i < 32; i++) begin
            rs1 = 5'(i);
            rs2 = 5'(32 - i);
            #1;
            check($sformatf("fill_rs1[%0d]", i), rs1_data_out, 32'(i) * 32'h01010101);
            check($sformatf("fill_rs2[%0d]", 32 - i), rs2_data_out, 32'(32 - i) * 32'h01010101);
        end

        // Randomized traffic against the reference model, checked before each edge.
        for (int n = 0; n < 400; n++) begin
            rst_n = ($urandom_range(0, 49) != 0);
            rd_write_enable = $urandom_range(0, 1) == 1;
            rd = 5'($urandom_range(0, 31));
            rd_data_in = $urandom;
            rs1 = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
            rs2 = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
            #1;
            check($sformatf("rand%0d_rs1", n), rs1_data_out, exp_read(rs1));
            check($sformatf("rand%0d_rs2", n), rs2_data_out, exp_read(rs2));
            tick();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
